// File: rtl/res_collector_pkg.sv
// -----------------------------------------------------------------------------
// res_collect_pkg
// Shared definitions for the result collector: FSM state encoding, default
// width constants and the buffer address-width helper.
// -----------------------------------------------------------------------------
package res_collect_pkg;

   localparam int DEF_NUM            = 100;
   localparam int DEF_ITEM_WIDTH     = 8;
   localparam int DEF_SUM_WIDTH      = 32;
   localparam int DEF_CNT_WIDTH      = 16;
   localparam int DEF_TIMEOUT_CYCLES = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

   // Buffer address width; never narrower than one bit.
   function automatic int addr_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/res_collector_if.sv
// -----------------------------------------------------------------------------
// res_collector_if
// Bundles the collector's control, result stream, read port and status.
//   master : the bfm / bench side (drives start, results, read requests)
//   slave  : the collector (drives read data and burst status)
// Optional: RES_COLLECT_TIMEOUT_EN adds the timeout_o status bit.
// -----------------------------------------------------------------------------
interface res_collector_if
   import res_collect_pkg::*;
#(
   parameter int ITEM_WIDTH = DEF_ITEM_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
   parameter int SUM_WIDTH  = DEF_SUM_WIDTH,
   parameter int ADDR_WIDTH = addr_width(DEF_NUM)
) ();

   logic                  start_i;
   logic [CNT_WIDTH-1:0]  item_num_i;
   logic                  res_valid_i;
   logic [ITEM_WIDTH-1:0] res_i;
   logic                  rd_en_i;
   logic [ADDR_WIDTH-1:0] rd_addr_i;
   logic [ITEM_WIDTH-1:0] rd_data_o;
   logic                  busy_o;
   logic                  done_o;
   logic [CNT_WIDTH-1:0]  count_o;
   logic [SUM_WIDTH-1:0]  sum_o;
   logic [ITEM_WIDTH-1:0] xor_o;
   logic                  overflow_o;
`ifdef RES_COLLECT_TIMEOUT_EN
   logic                  timeout_o;
`endif

   modport master (
      output start_i, item_num_i, res_valid_i, res_i, rd_en_i, rd_addr_i,
      input  rd_data_o, busy_o, done_o, count_o, sum_o, xor_o, overflow_o
`ifdef RES_COLLECT_TIMEOUT_EN
      , input timeout_o
`endif
   );

   modport slave (
      input  start_i, item_num_i, res_valid_i, res_i, rd_en_i, rd_addr_i,
      output rd_data_o, busy_o, done_o, count_o, sum_o, xor_o, overflow_o
`ifdef RES_COLLECT_TIMEOUT_EN
      , output timeout_o
`endif
   );

endinterface

// File: rtl/res_collector_buffer.sv
// -----------------------------------------------------------------------------
// res_buffer
// Simple dual-port RAM, NUM x ITEM_WIDTH. One write port, one registered read
// port with 1-cycle latency. A same-address read/write returns the old data.
// Out-of-range read addresses return 0. Contents are never reset; only the
// read register is.
// Ports: clk_i, reset_i, wr_en_i/wr_addr_i/wr_data_i, rd_en_i/rd_addr_i,
//        rd_data_o (holds when rd_en_i is low).
// -----------------------------------------------------------------------------
module res_buffer
   import res_collect_pkg::*;
#(
   parameter int NUM        = DEF_NUM,
   parameter int ITEM_WIDTH = DEF_ITEM_WIDTH,
   parameter int ADDR_WIDTH = addr_width(DEF_NUM)
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [ITEM_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [ITEM_WIDTH-1:0] rd_data_o
);

   localparam logic [ADDR_WIDTH:0] NUM_C = (ADDR_WIDTH+1)'(NUM);

   logic [ITEM_WIDTH-1:0] mem_r [NUM];
   logic [ITEM_WIDTH-1:0] rd_data_r;

   // Storage write; the array has no reset so it maps onto RAM.
   always_ff @(posedge clk_i) begin
      if (wr_en_i && ({1'b0, wr_addr_i} < NUM_C)) begin
         mem_r[wr_addr_i] <= wr_data_i;
      end
   end

   // Registered read; non-blocking semantics give old data on collision.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_data_r <= '0;
      end else if (rd_en_i) begin
         if ({1'b0, rd_addr_i} < NUM_C) begin
            rd_data_r <= mem_r[rd_addr_i];
         end else begin
            rd_data_r <= '0;
         end
      end
   end

   assign rd_data_o = rd_data_r;

endmodule

// File: rtl/res_collector.sv
// -----------------------------------------------------------------------------
// res_collector
// Collects the per-cycle result stream of one payload burst: stores each item
// in a local buffer and keeps an item count, a modular sum and an XOR
// checksum. done_o pulses for one cycle when the burst ends; the buffer stays
// readable through the registered read port in any state.
// Ports: clk_i, reset_i (sync, active-high), bus (res_collector_if.slave):
//   start_i/item_num_i   burst request and length (clamped to NUM)
//   res_valid_i/res_i    result stream
//   rd_en_i/rd_addr_i/rd_data_o  buffer read port, 1-cycle latency
//   busy_o, done_o, count_o, sum_o, xor_o, overflow_o  status
// Optional: RES_COLLECT_TIMEOUT_EN ends a burst after TIMEOUT_CYCLES idle
// cycles in COLLECT and flags it on timeout_o.
// -----------------------------------------------------------------------------
module res_collector
   import res_collect_pkg::*;
#(
   parameter int NUM            = DEF_NUM,
   parameter int ITEM_WIDTH     = DEF_ITEM_WIDTH,
   parameter int SUM_WIDTH      = DEF_SUM_WIDTH,
   parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input logic            clk_i,
   input logic            reset_i,
   res_collector_if.slave bus
);

   localparam int                   ADDR_WIDTH = addr_width(NUM);
   localparam logic [CNT_WIDTH-1:0] NUM_C      = CNT_WIDTH'(NUM);
   localparam logic [CNT_WIDTH-1:0] ONE_C      = CNT_WIDTH'(1);

   state_e                 state_r;
   logic [CNT_WIDTH-1:0]   target_r;
   logic [CNT_WIDTH-1:0]   count_r;
   logic [SUM_WIDTH-1:0]   sum_r;
   logic [ITEM_WIDTH-1:0]  xor_r;
   logic                   overflow_r;
   logic                   busy_r;
   logic                   done_r;
   logic [CNT_WIDTH-1:0]   start_tgt_s;
   logic                   wr_en_s;
   logic [ADDR_WIDTH-1:0]  wr_addr_s;
   logic [ITEM_WIDTH-1:0]  rd_data_s;

`ifdef RES_COLLECT_TIMEOUT_EN
   localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [GAP_W-1:0] gap_r;
   logic             timeout_r;
`endif

   // Requested burst length clamped to the buffer depth.
   always_comb begin
      if (bus.item_num_i > NUM_C) begin
         start_tgt_s = NUM_C;
      end else begin
         start_tgt_s = bus.item_num_i;
      end
   end

   // Buffer write decode: item 0 may arrive on the start cycle itself.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_addr_s = '0;
      case (state_r)
         ST_IDLE: begin
            if (bus.start_i && bus.res_valid_i && (start_tgt_s != '0)) begin
               wr_en_s = 1'b1;
            end else begin
               wr_en_s = 1'b0;
            end
         end
         ST_COLLECT: begin
            if (bus.res_valid_i) begin
               wr_en_s   = 1'b1;
               wr_addr_s = count_r[ADDR_WIDTH-1:0];
            end else begin
               wr_en_s = 1'b0;
            end
         end
         default: begin
            wr_en_s = 1'b0;
         end
      endcase
   end

   // Burst FSM with registered status outputs.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r    <= ST_IDLE;
         target_r   <= '0;
         count_r    <= '0;
         sum_r      <= '0;
         xor_r      <= '0;
         overflow_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
`ifdef RES_COLLECT_TIMEOUT_EN
         gap_r      <= '0;
         timeout_r  <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.start_i) begin
                  target_r <= start_tgt_s;
                  if (bus.item_num_i > NUM_C) begin
                     overflow_r <= 1'b1;
                  end
`ifdef RES_COLLECT_TIMEOUT_EN
                  gap_r     <= '0;
                  timeout_r <= 1'b0;
`endif
                  if (start_tgt_s == '0) begin
                     // Zero-length burst: no item can be accepted.
                     count_r <= '0;
                     sum_r   <= '0;
                     xor_r   <= '0;
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                     if (bus.res_valid_i) begin
                        overflow_r <= 1'b1;
                     end
                  end else if (bus.res_valid_i) begin
                     count_r <= ONE_C;
                     sum_r   <= SUM_WIDTH'(bus.res_i);
                     xor_r   <= bus.res_i;
                     if (start_tgt_s == ONE_C) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                     end else begin
                        state_r <= ST_COLLECT;
                        busy_r  <= 1'b1;
                     end
                  end else begin
                     count_r <= '0;
                     sum_r   <= '0;
                     xor_r   <= '0;
                     state_r <= ST_COLLECT;
                     busy_r  <= 1'b1;
                  end
               end else if (bus.res_valid_i) begin
                  overflow_r <= 1'b1;
               end
            end
            ST_COLLECT: begin
               if (bus.res_valid_i) begin
                  count_r <= count_r + ONE_C;
                  sum_r   <= sum_r + SUM_WIDTH'(bus.res_i);
                  xor_r   <= xor_r ^ bus.res_i;
`ifdef RES_COLLECT_TIMEOUT_EN
                  gap_r   <= '0;
`endif
                  if ((count_r + ONE_C) == target_r) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                     busy_r  <= 1'b0;
                  end
               end
`ifdef RES_COLLECT_TIMEOUT_EN
               // The idle cycle that brings the gap to TIMEOUT_CYCLES ends the burst.
               else if (gap_r == GAP_W'(TIMEOUT_CYCLES - 1)) begin
                  timeout_r <= 1'b1;
                  state_r   <= ST_DONE;
                  done_r    <= 1'b1;
                  busy_r    <= 1'b0;
               end else begin
                  gap_r <= gap_r + GAP_W'(1);
               end
`endif
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               if (bus.res_valid_i) begin
                  overflow_r <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   res_buffer #(
      .NUM        (NUM),
      .ITEM_WIDTH (ITEM_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_buffer (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .wr_en_i   (wr_en_s),
      .wr_addr_i (wr_addr_s),
      .wr_data_i (bus.res_i),
      .rd_en_i   (bus.rd_en_i),
      .rd_addr_i (bus.rd_addr_i),
      .rd_data_o (rd_data_s)
   );

   assign bus.rd_data_o  = rd_data_s;
   assign bus.busy_o     = busy_r;
   assign bus.done_o     = done_r;
   assign bus.count_o    = count_r;
   assign bus.sum_o      = sum_r;
   assign bus.xor_o      = xor_r;
   assign bus.overflow_o = overflow_r;
`ifdef RES_COLLECT_TIMEOUT_EN
   assign bus.timeout_o  = timeout_r;
`endif

endmodule

// File: doc/res_collector.md
Name: res_collector

Overview:
- Downstream stage of the bfm: consumes the per-cycle `res_o` result stream produced while a payload burst is transmitted.
- Per burst, stores every result in a local buffer and keeps a running item count, a modular sum and an XOR checksum.
- Signals burst completion so the testbench side can read results back through a registered read port (e.g. for DPI export) without halting simulation.

Parameters:
- NUM, 100, maximum results per burst (buffer depth)
- ITEM_WIDTH, 8, width of one result item
- SUM_WIDTH, 32, width of the running sum; wraps modulo 2^SUM_WIDTH
- CNT_WIDTH, 16, width of item_num_i and count_o
- TIMEOUT_CYCLES, 64, idle-gap limit; used only with the optional feature

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  begin a burst; sampled only in IDLE
- item_num_i  in  CNT_WIDTH  expected results in the burst; sampled with start_i
- res_valid_i  in  1  res_i is a valid result this cycle
- res_i  in  ITEM_WIDTH  result item from the bfm
- rd_en_i  in  1  buffer read request
- rd_addr_i  in  $clog2(NUM)  buffer read address
- rd_data_o  out  ITEM_WIDTH  read data; 1-cycle latency
- busy_o  out  1  high in COLLECT
- done_o  out  1  one-cycle pulse at burst end
- count_o  out  CNT_WIDTH  results accepted in the current/last burst
- sum_o  out  SUM_WIDTH  modular sum of accepted results (zero-extended)
- xor_o  out  ITEM_WIDTH  XOR of accepted results
- overflow_o  out  1  sticky: a valid result was dropped or item_num_i was clamped

Behaviour:
- Reset (sync, active-high): state IDLE; all outputs 0; buffer contents are not cleared. Reset mid-burst aborts the burst with no done_o pulse.
- States: IDLE, COLLECT, DONE.
- IDLE, start_i=1: latch target = min(item_num_i, NUM); set overflow_o if item_num_i > NUM; clear count_o/sum_o/xor_o; go to COLLECT. If target = 0, go directly to DONE instead.
- Start and result in the same cycle: if res_valid_i is also high on the start cycle, that item is accepted as item 0 (counts and checksums start from it, not from 0). The bfm stream may begin immediately.
- COLLECT: each res_valid_i writes buffer[count], then count+=1, sum+=res_i, xor^=res_i. When the accepted item makes count == target, move to DONE in the same edge. start_i is ignored in COLLECT.
- DONE: lasts exactly one cycle; done_o=1; then IDLE. A res_valid_i seen in DONE is dropped and sets overflow_o.
- IDLE, res_valid_i without start_i: item dropped; overflow_o set; counters and buffer unchanged.
- count_o, sum_o and xor_o hold their values in IDLE until the next start_i.
- overflow_o clears only on reset.
- Read port: legal in any state. rd_data_o = buffer[rd_addr_i] one cycle after rd_en_i. rd_addr_i >= NUM returns 0. rd_data_o holds its value when rd_en_i=0.
- Read/write same address, same cycle: returns the old data.

Optional Feature:
- Macro: RES_COLLECT_TIMEOUT_EN.
- Defined: adds output timeout_o (1 bit, sticky, cleared by start_i or reset) and a gap counter that resets on every res_valid_i in COLLECT.
  - When the gap counter reaches TIMEOUT_CYCLES in COLLECT, set timeout_o, go to DONE and pulse done_o.
  - count_o reflects the partial burst.
- Not defined: no port, no counter; COLLECT waits indefinitely.

Decomposition:
- Package res_collect_pkg holds:
  - state enum (IDLE, COLLECT, DONE)
  - default width constants
  - helper function for the address width (clog2 of NUM)
- Sub-module res_buffer: simple dual-port RAM, NUM x ITEM_WIDTH, one write port and one registered read port, read-old-data on collision.

Test Plan:
- Normal burst: start_i with item_num_i=4 and res_i 3,5,7,9 on consecutive cycles (the first on the start cycle) -> done_o pulses on the cycle after 9 is accepted; count_o=4, sum_o=24, xor_o=8; readback of addr 0..3 gives 3,5,7,9.
- Gapped burst: item_num_i=NUM (100), valid every other cycle, res_i=0xFF each -> done_o after the 100th item; sum_o=25500, xor_o=0; busy_o high throughout.
- Clamp and stray items:
  - item_num_i=150 -> overflow_o=1, done after 100 items.
  - A valid result in IDLE -> dropped, count_o unchanged.
- Zero length: item_num_i=0 -> DONE the next cycle; done_o pulses once; count_o=0.
- Reset mid-burst: reset_i asserted after 2 of 4 items -> no done_o; all outputs 0. A new burst of 2 items then completes with count_o=2.
- RES_COLLECT_TIMEOUT_EN with TIMEOUT_CYCLES=8: 3 of 5 items then silence -> timeout_o=1 and done_o pulse 8 cycles after the last item; count_o=3.
